// File: rtl/gpio_loader_pkg.sv
//=============================================================================
// Module      : gpio_loader_pkg
// Description : Shared types and constants for the GPIO serial loader:
//               sequencer state encoding, pad configuration word format and
//               storage address width.
// Revision    : 1.0 - initial release
//=============================================================================
`default_nettype none

package gpio_loader_pkg;

  // Pad configuration word format
  localparam int                  CFG_BITS    = 13;
  localparam logic [CFG_BITS-1:0] CFG_DEFAULT = 13'h0403;

  // Default chain length and the word address width it implies (two chains)
  localparam int PADS_PER_CHAIN_DEF = 19;
  localparam int ADDR_W             = $clog2(2 * PADS_PER_CHAIN_DEF);

  // Sequencer states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LOAD  = 2'd2,
    DONE  = 2'd3
  } loader_state_t;

endpackage : gpio_loader_pkg

`default_nettype wire

// File: rtl/gpio_loader_clkdiv.sv
//=============================================================================
// Module      : gpio_loader_clkdiv
// Description : Half-period tick generator for the loader shift clock.
//               Counts 0..DIV-1 while enabled and flags the last count;
//               a synchronous clear returns the count to zero.
// Revision    : 1.0 - initial release
//=============================================================================
`default_nettype none

module gpio_loader_clkdiv #(
  parameter int DIV = 2
) (
  input  logic clk,
  input  logic resetn,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int              CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] r_cnt;

  assign tick = en && (r_cnt == CNT_LAST);

  // Free-running modulo-DIV count while enabled; clear has priority
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (en) begin
      if (r_cnt == CNT_LAST) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

endmodule : gpio_loader_clkdiv

`default_nettype wire

// File: rtl/gpio_serial_loader.sv
//=============================================================================
// Module      : gpio_serial_loader
// Description : Holds one configuration word per user pad and, on start,
//               shifts both GPIO configuration chains MSB first in parallel,
//               then pulses the chain transfer strobe.
//               Optional build macro GPIO_LOADER_BITBANG_EN adds a bit-bang
//               pass-through of the loader outputs while idle.
// Revision    : 1.0 - initial release
//=============================================================================
`default_nettype none

module gpio_serial_loader
  import gpio_loader_pkg::*;
#(
  parameter int PADS_PER_CHAIN = PADS_PER_CHAIN_DEF,
  parameter int CLK_DIV        = 2
) (
  input  logic                clk,
  input  logic                resetn,
`ifdef GPIO_LOADER_BITBANG_EN
  input  logic                bb_enable,
  input  logic                bb_resetn,
  input  logic                bb_clock,
  input  logic                bb_load,
  input  logic                bb_data_1,
  input  logic                bb_data_2,
`endif
  input  logic                cfg_we,
  input  logic [ADDR_W-1:0]   cfg_addr,
  input  logic [CFG_BITS-1:0] cfg_wdata,
  output logic [CFG_BITS-1:0] cfg_rdata,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic                mprj_io_loader_resetn,
  output logic                mprj_io_loader_clock,
  output logic                mprj_io_loader_load,
  output logic                mprj_io_loader_data_1,
  output logic                mprj_io_loader_data_2
);

  localparam int NUM_WORDS = 2 * PADS_PER_CHAIN;
  localparam int WORD_W    = (PADS_PER_CHAIN > 1) ? $clog2(PADS_PER_CHAIN) : 1;
  localparam int BIT_W     = $clog2(CFG_BITS);

  localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(PADS_PER_CHAIN - 1);
  localparam logic [BIT_W-1:0]  TOP_BIT   = BIT_W'(CFG_BITS - 1);

  // Storage
  logic [CFG_BITS-1:0] r_mem [NUM_WORDS];

  // Sequencer state and counters
  loader_state_t     r_state;
  logic              r_phase;      // 0 = low half of a loader clock period
  logic [BIT_W-1:0]  r_bit;
  logic [WORD_W-1:0] r_word;

  // Registered loader outputs and status
  logic r_busy;
  logic r_done;
  logic r_ld_resetn;
  logic r_ld_clock;
  logic r_ld_load;
  logic r_data_1;
  logic r_data_2;

  logic                w_tick;
  logic                w_div_en;
  logic                w_div_clr;
  logic                w_start_ok;
  logic                w_wr_ok;
  logic [WORD_W-1:0]   w_sel_word;
  logic [BIT_W-1:0]    w_sel_bit;
  logic [ADDR_W-1:0]   w_addr_1;
  logic [ADDR_W-1:0]   w_addr_2;
  logic [CFG_BITS-1:0] w_word_1;
  logic [CFG_BITS-1:0] w_word_2;

  // Writes are only taken while idle and to an existing word
  assign w_wr_ok = cfg_we && !r_busy && (int'(cfg_addr) < NUM_WORDS);

  assign cfg_rdata = (int'(cfg_addr) < NUM_WORDS) ? r_mem[cfg_addr] : '0;

  // Word storage, every word back to its default on reset
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < NUM_WORDS; i++) begin
        r_mem[i] <= CFG_DEFAULT;
      end
    end else if (w_wr_ok) begin
      r_mem[cfg_addr] <= cfg_wdata;
    end
  end

  // Divider runs only while shifting or strobing load
  assign w_div_en  = (r_state == SHIFT) || (r_state == LOAD);
  assign w_div_clr = !w_div_en;

  gpio_loader_clkdiv #(
    .DIV (CLK_DIV)
  ) u_clkdiv (
    .clk    (clk),
    .resetn (resetn),
    .en     (w_div_en),
    .clr    (w_div_clr),
    .tick   (w_tick)
  );

  // Position of the bit to present next: first bit on start, else successor
  always_comb begin
    w_sel_word = r_word;
    w_sel_bit  = r_bit;
    if (r_state == IDLE) begin
      w_sel_word = '0;
      w_sel_bit  = TOP_BIT;
    end else if (r_bit == '0) begin
      w_sel_word = r_word + WORD_W'(1);
      w_sel_bit  = TOP_BIT;
    end else begin
      w_sel_bit  = r_bit - BIT_W'(1);
    end
  end

  // Chain 1 walks its words downward, chain 2 upward
  assign w_addr_1 = ADDR_W'(PADS_PER_CHAIN - 1) - ADDR_W'(w_sel_word);
  assign w_addr_2 = ADDR_W'(PADS_PER_CHAIN) + ADDR_W'(w_sel_word);

  // A write accepted in the start cycle must be visible to the first bit,
  // so the incoming data bypasses storage on an address match
  always_comb begin
    w_word_1 = '0;
    w_word_2 = '0;
    if (int'(w_addr_1) < NUM_WORDS) begin
      w_word_1 = (w_wr_ok && (cfg_addr == w_addr_1)) ? cfg_wdata : r_mem[w_addr_1];
    end
    if (int'(w_addr_2) < NUM_WORDS) begin
      w_word_2 = (w_wr_ok && (cfg_addr == w_addr_2)) ? cfg_wdata : r_mem[w_addr_2];
    end
  end

  // Load sequencer: shift both chains, strobe load, signal completion
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state     <= IDLE;
      r_phase     <= 1'b0;
      r_bit       <= '0;
      r_word      <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_ld_resetn <= 1'b0;
      r_ld_clock  <= 1'b0;
      r_ld_load   <= 1'b0;
      r_data_1    <= 1'b0;
      r_data_2    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_start_ok) begin
            r_state     <= SHIFT;
            r_busy      <= 1'b1;
            r_ld_resetn <= 1'b1;
            r_ld_clock  <= 1'b0;
            r_phase     <= 1'b0;
            r_word      <= w_sel_word;
            r_bit       <= w_sel_bit;
            r_data_1    <= w_word_1[w_sel_bit];
            r_data_2    <= w_word_2[w_sel_bit];
          end
        end
        SHIFT: begin
          if (w_tick) begin
            if (!r_phase) begin
              r_phase    <= 1'b1;
              r_ld_clock <= 1'b1;
            end else begin
              r_phase    <= 1'b0;
              r_ld_clock <= 1'b0;
              if ((r_bit == '0) && (r_word == LAST_WORD)) begin
                r_state   <= LOAD;
                r_ld_load <= 1'b1;
                r_data_1  <= 1'b0;
                r_data_2  <= 1'b0;
              end else begin
                r_word   <= w_sel_word;
                r_bit    <= w_sel_bit;
                r_data_1 <= w_word_1[w_sel_bit];
                r_data_2 <= w_word_2[w_sel_bit];
              end
            end
          end
        end
        LOAD: begin
          if (w_tick) begin
            if (!r_phase) begin
              r_phase <= 1'b1;
            end else begin
              r_phase   <= 1'b0;
              r_ld_load <= 1'b0;
              r_busy    <= 1'b0;
              r_done    <= 1'b1;
              r_state   <= DONE;
            end
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;

`ifdef GPIO_LOADER_BITBANG_EN
  logic w_bb_active;

  // Bit-bang only takes over an idle sequencer; a running load finishes first
  assign w_bb_active = bb_enable && (r_state == IDLE);
  assign w_start_ok  = start && !bb_enable;

  assign mprj_io_loader_resetn = w_bb_active ? bb_resetn : r_ld_resetn;
  assign mprj_io_loader_clock  = w_bb_active ? bb_clock  : r_ld_clock;
  assign mprj_io_loader_load   = w_bb_active ? bb_load   : r_ld_load;
  assign mprj_io_loader_data_1 = w_bb_active ? bb_data_1 : r_data_1;
  assign mprj_io_loader_data_2 = w_bb_active ? bb_data_2 : r_data_2;
`else
  assign w_start_ok = start;

  assign mprj_io_loader_resetn = r_ld_resetn;
  assign mprj_io_loader_clock  = r_ld_clock;
  assign mprj_io_loader_load   = r_ld_load;
  assign mprj_io_loader_data_1 = r_data_1;
  assign mprj_io_loader_data_2 = r_data_2;
`endif

endmodule : gpio_serial_loader

`default_nettype wire
